// File: rtl/lca_mem_pkg.sv
`default_nettype none
// lca_mem_pkg: shared types for the store write buffer.
// Rev 1.0
package lca_mem_pkg;

    localparam int SWB_DEFAULT_ENTRIES = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } swb_entry_t;

    typedef enum logic [1:0] {
        SWB_IDLE     = 2'd0,
        SWB_REQ      = 2'd1,
        SWB_WAIT_ACK = 2'd2
    } swb_state_e;

endpackage
`default_nettype wire

// File: rtl/swb_fwd_lookup.sv
`default_nettype none
// swb_fwd_lookup: combinational youngest-match search over the valid buffer entries.
// Rev 1.0
module swb_fwd_lookup
    import lca_mem_pkg::*;
#(
    parameter int SWB_ENTRIES = SWB_DEFAULT_ENTRIES,
    parameter int PTR_W       = $clog2(SWB_ENTRIES) + 1
) (
    input  swb_entry_t       entries [SWB_ENTRIES],
    input  logic [PTR_W-1:0] head,
    input  logic [PTR_W-1:0] count,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data
);
    localparam int IDX_W = PTR_W - 1;

    logic [IDX_W-1:0] idx;
    logic [31:0]      ld_word;
    logic             unused_bits;

    assign ld_word     = {ld_addr[31:2], 2'b00};
    assign unused_bits = ^ld_addr[1:0];

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int i = 0; i < SWB_ENTRIES; i++) begin
            idx = head[IDX_W-1:0] + IDX_W'(i);
            if ((PTR_W'(i) < count) && (entries[idx].addr == ld_word)) begin
                ld_hit  = 1'b1;
                ld_data = entries[idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// store_write_buffer: in-order store retirement buffer with coalescing and load forwarding.
// Rev 1.0
module store_write_buffer
    import lca_mem_pkg::*;
#(
    parameter int SWB_ENTRIES = SWB_DEFAULT_ENTRIES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_vld,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_rdy,
    output logic        mem_req_vld,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_req_rdy,
    input  logic        mem_ack,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        drained,
    output logic        overflow_err
);
    localparam int IDX_W = $clog2(SWB_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    swb_entry_t       entries [SWB_ENTRIES];
    swb_state_e       state;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] young_idx;
    logic [IDX_W-1:0] src_idx;
    logic [31:0]      st_word;
    logic [31:0]      src_data;
    logic             full;
    logic             push;
    logic             young_busy;
    logic             coalesce;
    logic             pop;
    logic             unused_bits;

    assign count       = tail - head;
    assign head_idx    = head[IDX_W-1:0];
    assign tail_idx    = tail[IDX_W-1:0];
    assign young_idx   = tail_idx - IDX_W'(1);
    assign full        = (count == PTR_W'(SWB_ENTRIES));
    assign st_rdy      = ~full;
    assign st_word     = {st_addr[31:2], 2'b00};
    assign unused_bits = ^st_addr[1:0];
    assign push        = st_vld & ~full;
    assign young_busy  = (state != SWB_IDLE) && (count == PTR_W'(1));
    assign coalesce    = push && (count != '0) && !young_busy &&
                         (entries[young_idx].addr == st_word);
    assign pop         = (state == SWB_WAIT_ACK) && mem_ack;
    assign drained     = (count == '0) && (state == SWB_IDLE);

    // Next request comes from head, or head+1 when the current write is retiring.
    // A merge landing in that same entry this cycle must be seen by the request.
    assign src_idx  = (state == SWB_WAIT_ACK) ? head_idx + IDX_W'(1) : head_idx;
    assign src_data = (coalesce && (young_idx == src_idx)) ? st_data : entries[src_idx].data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SWB_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            head         <= '0;
            tail         <= '0;
            state        <= SWB_IDLE;
            mem_req_vld  <= 1'b0;
            mem_req_addr <= '0;
            mem_req_data <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (st_vld && full) begin
                overflow_err <= 1'b1;
            end
            if (coalesce) begin
                entries[young_idx].data <= st_data;
            end else if (push) begin
                entries[tail_idx] <= '{addr: st_word, data: st_data};
                tail              <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case (state)
                SWB_IDLE: begin
                    if (count != '0) begin
                        state        <= SWB_REQ;
                        mem_req_vld  <= 1'b1;
                        mem_req_addr <= entries[src_idx].addr;
                        mem_req_data <= src_data;
                    end
                end
                SWB_REQ: begin
                    if (mem_req_rdy) begin
                        state       <= SWB_WAIT_ACK;
                        mem_req_vld <= 1'b0;
                    end
                end
                SWB_WAIT_ACK: begin
                    if (mem_ack) begin
                        if (count > PTR_W'(1)) begin
                            state        <= SWB_REQ;
                            mem_req_vld  <= 1'b1;
                            mem_req_addr <= entries[src_idx].addr;
                            mem_req_data <= src_data;
                        end else begin
                            state <= SWB_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= SWB_IDLE;
                    mem_req_vld <= 1'b0;
                end
            endcase
        end
    end

    swb_fwd_lookup #(
        .SWB_ENTRIES (SWB_ENTRIES),
        .PTR_W       (PTR_W)
    ) u_fwd (
        .entries (entries),
        .head    (head),
        .count   (count),
        .ld_addr (ld_addr),
        .ld_hit  (ld_hit),
        .ld_data (ld_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// tb_store_write_buffer: scoreboard bench with a simple memory responder model.
// Rev 1.0
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_vld;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_rdy;
    logic        mem_req_vld;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_req_rdy;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        drained;
    logic        overflow_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          ack_delay = 1;
    int          ack_cnt;
    logic        spur_ack = 1'b0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    store_write_buffer #(.SWB_ENTRIES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_vld       (st_vld),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_rdy       (st_rdy),
        .mem_req_vld  (mem_req_vld),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_req_rdy  (mem_req_rdy),
        .mem_ack      (mem_ack),
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .ld_data      (ld_data),
        .drained      (drained),
        .overflow_err (overflow_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        st_vld  = 1'b1;
        st_addr = a;
        st_data = d;
        tick();
        st_vld  = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] a,
                          input logic hit, input logic [31:0] d);
        ld_addr = a;
        #1;
        check({tag, "_hit"}, 32'(ld_hit), 32'(hit));
        check({tag, "_data"}, ld_data, d);
    endtask

    task automatic wait_drained(input string tag, input int budget);
        for (int i = 0; i < budget && !drained; i++) tick();
        check(tag, 32'(drained), 32'd1);
    endtask

    // Memory responder: checks writes against the scoreboard and returns acks.
    initial begin : mem_model
        logic        prev_vld;
        logic        prev_rdy;
        logic [31:0] prev_addr;
        logic [31:0] prev_data;
        logic [63:0] exp;
        mem_ack  = 1'b0;
        ack_cnt  = 0;
        prev_vld = 1'b0;
        prev_rdy = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ack_cnt  = 0;
                mem_ack  = 1'b0;
                prev_vld = 1'b0;
            end else begin
                mem_ack = spur_ack;
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) mem_ack = 1'b1;
                end
                if (prev_vld && !prev_rdy && mem_req_vld) begin
                    check("req_addr_hold", mem_req_addr, prev_addr);
                    check("req_data_hold", mem_req_data, prev_data);
                end
                if (mem_req_vld && mem_req_rdy) begin
                    n_writes++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", mem_req_addr, 32'hFFFF_FFFF);
                    end else begin
                        exp = exp_q.pop_front();
                        check("wr_addr", mem_req_addr, exp[63:32]);
                        check("wr_data", mem_req_data, exp[31:0]);
                    end
                    ack_cnt = ack_delay;
                end
                prev_vld  = mem_req_vld;
                prev_rdy  = mem_req_rdy;
                prev_addr = mem_req_addr;
                prev_data = mem_req_data;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w0;
        rst         = 1'b0;
        st_vld      = 1'b0;
        st_addr     = '0;
        st_data     = '0;
        mem_req_rdy = 1'b0;
        ld_addr     = 32'h0000_0100;
        repeat (3) tick();

        // Reset values
        check("rst_st_rdy", 32'(st_rdy), 32'd1);
        check("rst_vld", 32'(mem_req_vld), 32'd0);
        check("rst_addr", mem_req_addr, 32'd0);
        check("rst_data", mem_req_data, 32'd0);
        check("rst_drained", 32'(drained), 32'd1);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        lookup("rst_ld", 32'h0000_0100, 1'b0, 32'd0);
        rst = 1'b1;
        tick();

        // Single store: latency and drain after ack
        mem_req_rdy = 1'b1;
        ack_delay   = 3;
        exp_q.push_back({32'h0000_0100, 32'hDEAD_BEEF});
        push(32'h0000_0100, 32'hDEAD_BEEF);
        check("lat_n1_vld", 32'(mem_req_vld), 32'd0);
        check("lat_n1_drained", 32'(drained), 32'd0);
        lookup("single_ld", 32'h0000_0101, 1'b1, 32'hDEAD_BEEF);
        tick();
        check("lat_n2_vld", 32'(mem_req_vld), 32'd1);
        check("lat_n2_addr", mem_req_addr, 32'h0000_0100);
        check("lat_n2_data", mem_req_data, 32'hDEAD_BEEF);
        for (int i = 0; i < 20 && !drained; i++) tick();
        check("single_drained", 32'(drained), 32'd1);
        check("drain_at_ack", 32'(mem_ack), 32'd1);

        // Fill and overflow
        mem_req_rdy = 1'b0;
        ack_delay   = 1;
        w0 = n_writes;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({32'h0000_1000 + 32'(4 * i), 32'h0000_0A00 + 32'(i)});
            if (i == 3) check("fill_rdy_before_last", 32'(st_rdy), 32'd1);
            push(32'h0000_1000 + 32'(4 * i), 32'h0000_0A00 + 32'(i));
        end
        check("full_st_rdy", 32'(st_rdy), 32'd0);
        check("full_ovf_before", 32'(overflow_err), 32'd0);
        push(32'h0000_1010, 32'h0000_0BAD);
        check("ovf_set", 32'(overflow_err), 32'd1);
        lookup("ovf_dropped", 32'h0000_1010, 1'b0, 32'd0);
        mem_req_rdy = 1'b1;
        wait_drained("fill_drained", 100);
        check("fill_writes", 32'(n_writes - w0), 32'd4);
        check("fill_sb_empty", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky", 32'(overflow_err), 32'd1);

        // Coalesce into a non-in-flight youngest entry
        mem_req_rdy = 1'b0;
        w0 = n_writes;
        exp_q.push_back({32'h0000_0200, 32'h0000_0001});
        exp_q.push_back({32'h0000_0204, 32'h0000_0003});
        push(32'h0000_0200, 32'h0000_0001);
        push(32'h0000_0204, 32'h0000_0002);
        push(32'h0000_0204, 32'h0000_0003);
        lookup("coal_ld", 32'h0000_0204, 1'b1, 32'h0000_0003);
        mem_req_rdy = 1'b1;
        wait_drained("coal_drained", 100);
        check("coal_writes", 32'(n_writes - w0), 32'd2);
        check("coal_sb_empty", 32'(exp_q.size()), 32'd0);

        // No merge into the in-flight head
        mem_req_rdy = 1'b0;
        w0 = n_writes;
        exp_q.push_back({32'h0000_0200, 32'h0000_0005});
        exp_q.push_back({32'h0000_0200, 32'h0000_0009});
        push(32'h0000_0200, 32'h0000_0005);
        tick();
        check("inflight_vld", 32'(mem_req_vld), 32'd1);
        push(32'h0000_0200, 32'h0000_0009);
        lookup("inflight_ld", 32'h0000_0200, 1'b1, 32'h0000_0009);
        mem_req_rdy = 1'b1;
        wait_drained("inflight_drained", 100);
        check("inflight_writes", 32'(n_writes - w0), 32'd2);
        check("inflight_sb_empty", 32'(exp_q.size()), 32'd0);

        // Forwarding youngest match from non-adjacent slots
        mem_req_rdy = 1'b0;
        exp_q.push_back({32'h0000_0300, 32'h0000_000A});
        exp_q.push_back({32'h0000_0310, 32'h0000_000C});
        exp_q.push_back({32'h0000_0300, 32'h0000_000B});
        push(32'h0000_0300, 32'h0000_000A);
        push(32'h0000_0310, 32'h0000_000C);
        push(32'h0000_0300, 32'h0000_000B);
        lookup("fwd_young", 32'h0000_0302, 1'b1, 32'h0000_000B);
        lookup("fwd_miss", 32'h0000_0400, 1'b0, 32'd0);
        lookup("fwd_mid", 32'h0000_0310, 1'b1, 32'h0000_000C);
        mem_req_rdy = 1'b1;
        wait_drained("fwd_drained", 100);
        check("fwd_sb_empty", 32'(exp_q.size()), 32'd0);

        // Request hold with a spurious ack during REQ
        mem_req_rdy = 1'b0;
        w0 = n_writes;
        exp_q.push_back({32'h0000_0500, 32'h0000_0055});
        push(32'h0000_0500, 32'h0000_0055);
        for (int i = 0; i < 10 && !mem_req_vld; i++) tick();
        check("hold_vld_up", 32'(mem_req_vld), 32'd1);
        for (int i = 0; i < 4; i++) begin
            spur_ack = (i == 1);
            tick();
            check("hold_vld", 32'(mem_req_vld), 32'd1);
            check("hold_addr", mem_req_addr, 32'h0000_0500);
            check("hold_data", mem_req_data, 32'h0000_0055);
        end
        spur_ack = 1'b0;
        lookup("spur_no_pop", 32'h0000_0500, 1'b1, 32'h0000_0055);
        check("spur_not_drained", 32'(drained), 32'd0);
        mem_req_rdy = 1'b1;
        wait_drained("hold_drained", 100);
        check("hold_writes", 32'(n_writes - w0), 32'd1);

        // Asynchronous reset while in WAIT_ACK with 3 entries
        mem_req_rdy = 1'b0;
        ack_delay   = 50;
        exp_q.push_back({32'h0000_0600, 32'h0000_0006});
        push(32'h0000_0600, 32'h0000_0006);
        push(32'h0000_0604, 32'h0000_0007);
        push(32'h0000_0608, 32'h0000_0008);
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        check("pre_rst_vld", 32'(mem_req_vld), 32'd0);
        check("pre_rst_drained", 32'(drained), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_vld", 32'(mem_req_vld), 32'd0);
        check("arst_addr", mem_req_addr, 32'd0);
        check("arst_data", mem_req_data, 32'd0);
        check("arst_st_rdy", 32'(st_rdy), 32'd1);
        check("arst_drained", 32'(drained), 32'd1);
        check("arst_ovf", 32'(overflow_err), 32'd0);
        lookup("arst_ld", 32'h0000_0604, 1'b0, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        w0 = n_writes;
        mem_req_rdy = 1'b1;
        ack_delay   = 1;
        repeat (20) tick();
        check("post_rst_writes", 32'(n_writes - w0), 32'd0);
        check("post_rst_drained", 32'(drained), 32'd1);
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
